// File: rtl/shift_seq_unit.sv
`default_nettype none
// ============================================================================
// Module  : shift_seq_unit
// Brief   : Iterative one-bit-per-clock shifter (SRL/SLL/SRA/ROR) with carry.
// Revision: 1.0
// ============================================================================
module shift_seq_unit #(
   parameter int N  = 8,
   parameter int SW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [SW-1:0] shamt,
   input  logic [N-1:0]  dataa,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  dataout,
   output logic          carry
);

   localparam logic [1:0] C_IDLE  = 2'd0;
   localparam logic [1:0] C_SHIFT = 2'd1;
   localparam logic [1:0] C_DONE  = 2'd2;

   localparam logic [1:0] C_OP_SRL = 2'b00;
   localparam logic [1:0] C_OP_SLL = 2'b01;
   localparam logic [1:0] C_OP_SRA = 2'b10;
   localparam logic [1:0] C_OP_ROR = 2'b11;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  work_q, work_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [1:0]    op_q, op_d;
   logic [N-1:0]  dataout_q, dataout_d;
   logic          carry_q, carry_d;

   logic [N-1:0]  step_val;
   logic          step_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= C_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         C_IDLE:  if (start) state_d = (shamt != '0) ? C_SHIFT : C_DONE;
         C_SHIFT: if (cnt_q == SW'(1)) state_d = C_DONE;
         C_DONE:  state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == C_SHIFT) || (state_q == C_DONE);
      done = (state_q == C_DONE);
   end

   // Single-bit step applied to the work register under the latched op.
   always_comb begin
      step_val = work_q;
      step_bit = 1'b0;
      case (op_q)
         C_OP_SRL: begin step_val = {1'b0, work_q[N-1:1]};         step_bit = work_q[0];   end
         C_OP_SLL: begin step_val = {work_q[N-2:0], 1'b0};         step_bit = work_q[N-1]; end
         C_OP_SRA: begin step_val = {work_q[N-1], work_q[N-1:1]};  step_bit = work_q[0];   end
         C_OP_ROR: begin step_val = {work_q[0], work_q[N-1:1]};    step_bit = work_q[0];   end
      endcase
   end

   always_comb begin
      work_d    = work_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      dataout_d = dataout_q;
      carry_d   = carry_q;
      if (state_q == C_IDLE) begin
         if (start) begin
            work_d = dataa;
            op_d   = op;
            cnt_d  = shamt;
            if (shamt == '0) begin
               dataout_d = dataa;
               carry_d   = 1'b0;
            end
         end
      end else if (state_q == C_SHIFT) begin
         work_d = step_val;
         cnt_d  = cnt_q - SW'(1);
         // Result and carry are published only on the final step.
         if (cnt_q == SW'(1)) begin
            dataout_d = step_val;
            carry_d   = step_bit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q    <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         dataout_q <= '0;
         carry_q   <= 1'b0;
      end else begin
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         dataout_q <= dataout_d;
         carry_q   <= carry_d;
      end
   end

   assign dataout = dataout_q;
   assign carry   = carry_q;

endmodule
`default_nettype wire

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Iterative multi-cycle shifter: accepts an N-bit operand, a shift amount and an operation.
- Shifts one bit position per clock and reports the result with a one-cycle done pulse.
- Extends the ALU shift path to variable amounts, arithmetic shifts and rotates, plus a carry-out flag.
- Sits beside the combinational ALU datapath, driven by the ALU control FSM through a start/busy/done handshake.

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- SW, 3, shift-amount width; must equal clog2(N); max shift = 2^SW - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 logical right, 01 logical left, 10 arithmetic right, 11 rotate right.
- shamt  input  SW  number of single-bit shifts to perform.
- dataa  input  N  operand.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; result valid.
- dataout  output  N  registered result; held until next result is written.
- carry  output  1  last bit shifted out; 0 when shamt = 0.

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-shift): state = IDLE; busy = 0, done = 0, dataout = 0, carry = 0; internal work register and counter = 0. Any operation in progress is abandoned with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: busy = 0, done = 0.
  - On a clock edge with start = 1, latch dataa into the work register and latch op.
  - shamt != 0: counter = shamt, go to SHIFT.
  - shamt = 0: dataout = dataa, carry = 0, go to DONE.
- SHIFT: each edge applies one single-bit step to the work register per latched op, sets the internal carry to the bit shifted out, and decrements the counter.
  - The edge that performs the final step (counter = 1) also writes dataout = shifted value and carry = that step's out-bit, then goes to DONE.
- DONE: done = 1 for exactly one cycle, busy = 1; next edge returns to IDLE.
- Latency:
  - start sampled at edge k gives done high in the cycle after edge k + shamt.
  - shamt = 0 gives done in the cycle after edge k.
  - Next start can be sampled at edge k + shamt + 2 at the earliest.
- start while busy (SHIFT or DONE) is ignored. dataa, op and shamt may change freely after acceptance.
- Step definitions (w = work register):
  - op 00: w = {0, w[N-1:1]}, out-bit = w[0].
  - op 01: w = {w[N-2:0], 0}, out-bit = w[N-1].
  - op 10: w = {w[N-1], w[N-1:1]}, out-bit = w[0].
  - op 11: w = {w[0], w[N-1:1]}, out-bit = w[0].
- dataout and carry change only on the edge entering DONE, or on reset; they are stable in all other cycles.
- Shift amounts >= N are legal for logical/arithmetic ops:
  - logical results are 0;
  - arithmetic right results are all copies of the sign bit;
  - rotates wrap modulo N naturally.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset then dataa = 0xB4, op = 00, shamt = 1, start pulse at edge k -> done in cycle after edge k+1; dataout = 0x5A, carry = 0; busy high for 2 cycles.
2. dataa = 0xB4, op = 01, shamt = 3 -> done after edge k+3; dataout = 0xA0, carry = 1; dataout unchanged (0x5A from test 1) until that edge.
3. dataa = 0x81, op = 10, shamt = 7 -> dataout = 0xFF, carry = 0; then op = 11, shamt = 1, dataa = 0x81 -> dataout = 0xC0, carry = 1.
4. dataa = 0x3C, shamt = 0, start held high for 4 cycles -> done exactly once, in the cycle after edge k; dataout = 0x3C, carry = 0; a second operation is accepted only when start is sampled in IDLE (edge k+2).
5. Start op = 00, shamt = 7, dataa = 0xFF; assert rst_n low after 3 shift edges -> outputs immediately 0, no done pulse; after release, a new op = 01, shamt = 2, dataa = 0x01 gives dataout = 0x04, carry = 0.
6. Random back-to-back operations (all ops, shamt 0..7) against a reference model -> every dataout and carry matches; done count equals accepted starts; busy never high in IDLE.
